// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register.
// Handles sequential fetch, ID-stage jump redirect, EX-stage branch flush, stall and perf counters.
module if_fetch_stage #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter logic [2:0]  JUMP_OP  = 3'd7,
   parameter int          CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset,
   output logic [15:0]      imem_addr,
   input  logic [15:0]      imem_data,
   input  logic             stall,
   input  logic             branch_taken,
   input  logic [15:0]      branch_target,
   output logic [15:0]      if_id_instr,
   output logic [2:0]       if_id_opcode,
   output logic [15:0]      if_id_pc2,
   output logic             if_id_valid,
   output logic [CNT_W-1:0] fetch_count,
   output logic [CNT_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [15:0]      pcReg, pcNext;
   logic [15:0]      instrReg, instrNext;
   logic [15:0]      pc2Reg, pc2Next;
   logic             validReg, validNext;
   logic [CNT_W-1:0] fetchCntReg, fetchCntNext;
   logic [CNT_W-1:0] flushCntReg, flushCntNext;

   logic             jumpId;
   logic [15:0]      jumpTarget;
   logic [15:0]      pcPlus2;

   // The jump is decoded from the word already sitting in IF/ID; its target keeps the page bits of PC+2.
   assign jumpId     = validReg && (instrReg[15:13] == JUMP_OP);
   assign jumpTarget = {pc2Reg[15:14], instrReg[12:0], 1'b0};
   assign pcPlus2    = pcReg + 16'd2;

   always_comb begin
      pcNext       = pcReg;
      instrNext    = instrReg;
      pc2Next      = pc2Reg;
      validNext    = validReg;
      fetchCntNext = fetchCntReg;
      flushCntNext = flushCntReg;
      if (branch_taken) begin
         // The branch is older than anything in IF/ID, so it beats stall and jump.
         pcNext       = branch_target;
         instrNext    = 16'h0000;
         pc2Next      = 16'h0000;
         validNext    = 1'b0;
         flushCntNext = flushCntReg + CNT_ONE;
      end else if (stall) begin
         pcNext = pcReg;
      end else if (jumpId) begin
         pcNext       = jumpTarget;
         instrNext    = 16'h0000;
         pc2Next      = 16'h0000;
         validNext    = 1'b0;
         flushCntNext = flushCntReg + CNT_ONE;
      end else begin
         pcNext       = pcPlus2;
         instrNext    = imem_data;
         pc2Next      = pcPlus2;
         validNext    = 1'b1;
         fetchCntNext = fetchCntReg + CNT_ONE;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pcReg       <= RESET_PC;
         instrReg    <= 16'h0000;
         pc2Reg      <= 16'h0000;
         validReg    <= 1'b0;
         fetchCntReg <= '0;
         flushCntReg <= '0;
      end else begin
         pcReg       <= pcNext;
         instrReg    <= instrNext;
         pc2Reg      <= pc2Next;
         validReg    <= validNext;
         fetchCntReg <= fetchCntNext;
         flushCntReg <= flushCntNext;
      end
   end

   assign imem_addr    = pcReg;
   assign if_id_instr  = instrReg;
   assign if_id_opcode = instrReg[15:13];
   assign if_id_pc2    = pc2Reg;
   assign if_id_valid  = validReg;
   assign fetch_count  = fetchCntReg;
   assign flush_count  = flushCntReg;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed and randomized checks of if_fetch_stage against a cycle-level behavioural model.
// A second instance with RESET_PC=16'hFFFC covers PC wrap-around.
module tb_if_fetch_stage;

   logic        clock;
   logic        resetA, resetB;
   logic        stallA, branchA;
   logic [15:0] targetA;
   logic [15:0] addrA, dataA, instrA, pc2A, fetchA, flushA;
   logic [2:0]  opA;
   logic        validA;
   logic [15:0] addrB, dataB, instrB, pc2B, fetchB, flushB;
   logic [2:0]  opB;
   logic        validB;
   logic        zeroBit;
   logic [15:0] zeroWord;

   logic [15:0] mem [0:32767];

   int testsRun;
   int testsFailed;

   // behavioural model of instance A
   logic [15:0] mPc, mInstr, mPc2, mFetch, mFlush;
   logic        mValid, mPc2Known;

   assign dataA = mem[addrA[15:1]];
   assign dataB = mem[addrB[15:1]];

   if_fetch_stage #(.RESET_PC(16'h0000), .JUMP_OP(3'd7), .CNT_W(16)) dutA (
      .clock(clock), .reset(resetA), .imem_addr(addrA), .imem_data(dataA),
      .stall(stallA), .branch_taken(branchA), .branch_target(targetA),
      .if_id_instr(instrA), .if_id_opcode(opA), .if_id_pc2(pc2A), .if_id_valid(validA),
      .fetch_count(fetchA), .flush_count(flushA)
   );

   if_fetch_stage #(.RESET_PC(16'hFFFC), .JUMP_OP(3'd7), .CNT_W(16)) dutB (
      .clock(clock), .reset(resetB), .imem_addr(addrB), .imem_data(dataB),
      .stall(zeroBit), .branch_taken(zeroBit), .branch_target(zeroWord),
      .if_id_instr(instrB), .if_id_opcode(opB), .if_id_pc2(pc2B), .if_id_valid(validB),
      .fetch_count(fetchB), .flush_count(flushB)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      testsRun++;
      assert (obs === exp) else begin
         testsFailed++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checkModel(input string tag);
      check({tag, "_addr"},  {16'h0, addrA},  {16'h0, mPc});
      check({tag, "_instr"}, {16'h0, instrA}, {16'h0, mInstr});
      check({tag, "_op"},    {29'h0, opA},    {29'h0, mInstr[15:13]});
      check({tag, "_valid"}, {31'h0, validA}, {31'h0, mValid});
      if (mPc2Known) check({tag, "_pc2"}, {16'h0, pc2A}, {16'h0, mPc2});
      check({tag, "_fetch"}, {16'h0, fetchA}, {16'h0, mFetch});
      check({tag, "_flush"}, {16'h0, flushA}, {16'h0, mFlush});
   endtask

   // One clock of instance A: apply inputs, advance the model by the priority rules, compare.
   task automatic stepA(input string tag, input logic r, input logic s, input logic b, input logic [15:0] t);
      logic [15:0] word;
      logic        jmp;
      resetA  = r;
      stallA  = s;
      branchA = b;
      targetA = t;
      word = mem[mPc[15:1]];
      jmp  = mValid && (mInstr[15:13] == 3'd7);
      if (r) begin
         mPc = 16'h0000; mInstr = 16'h0; mPc2 = 16'h0; mValid = 1'b0;
         mFetch = 16'h0; mFlush = 16'h0; mPc2Known = 1'b1;
      end else if (b) begin
         mPc = t; mInstr = 16'h0; mPc2 = 16'h0; mValid = 1'b0;
         mFlush = mFlush + 16'd1; mPc2Known = 1'b1;
      end else if (s) begin
         mFetch = mFetch;
      end else if (jmp) begin
         mPc = {mPc2[15:14], mInstr[12:0], 1'b0};
         mInstr = 16'h0; mValid = 1'b0; mPc2Known = 1'b0;
         mFlush = mFlush + 16'd1;
      end else begin
         mInstr = word; mPc2 = mPc + 16'd2; mPc = mPc + 16'd2;
         mValid = 1'b1; mPc2Known = 1'b1; mFetch = mFetch + 16'd1;
      end
      @(posedge clock);
      #1;
      checkModel(tag);
      $display("[TB] %s rst=%0b stall=%0b br=%0b pc=%h instr=%h pc2=%h valid=%0b fetch=%0d flush=%0d",
               tag, r, s, b, addrA, instrA, pc2A, validA, fetchA, flushA);
   endtask

   initial begin
      testsRun    = 0;
      testsFailed = 0;
      zeroBit  = 1'b0;
      zeroWord = 16'h0;
      resetA = 1'b1; resetB = 1'b1;
      stallA = 1'b0; branchA = 1'b0; targetA = 16'h0;
      mPc = 16'h0; mInstr = 16'h0; mPc2 = 16'h0; mValid = 1'b0;
      mFetch = 16'h0; mFlush = 16'h0; mPc2Known = 1'b1;
      for (int i = 0; i < 32768; i++) mem[i] = 16'($urandom);

      // sequential fetch
      mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
      stepA("seq_rst", 1'b1, 1'b0, 1'b0, 16'h0);
      check("seq_rst_instr", {16'h0, instrA}, 32'h0);
      stepA("seq1", 1'b0, 1'b0, 1'b0, 16'h0);
      check("seq1_instr", {16'h0, instrA}, 32'h1111);
      stepA("seq2", 1'b0, 1'b0, 1'b0, 16'h0);
      check("seq2_pc2", {16'h0, pc2A}, 32'h4);
      stepA("seq3", 1'b0, 1'b0, 1'b0, 16'h0);
      check("seq3_instr", {16'h0, instrA}, 32'h3333);
      check("seq3_addr",  {16'h0, addrA},  32'h6);
      check("seq3_fetch", {16'h0, fetchA}, 32'h3);

      // jump at address 4 into 16'h0020
      mem[2] = 16'hE010; mem[3] = 16'h6666; mem[16] = 16'hABCD;
      stepA("jmp_rst", 1'b1, 1'b0, 1'b0, 16'h0);
      stepA("jmp1", 1'b0, 1'b0, 1'b0, 16'h0);
      stepA("jmp2", 1'b0, 1'b0, 1'b0, 16'h0);
      stepA("jmp3", 1'b0, 1'b0, 1'b0, 16'h0);
      check("jmp3_op", {29'h0, opA}, 32'h7);
      stepA("jmp4", 1'b0, 1'b0, 1'b0, 16'h0);
      check("jmp4_addr",  {16'h0, addrA},  32'h20);
      check("jmp4_instr", {16'h0, instrA}, 32'h0);
      check("jmp4_valid", {31'h0, validA}, 32'h0);
      check("jmp4_flush", {16'h0, flushA}, 32'h1);
      stepA("jmp5", 1'b0, 1'b0, 1'b0, 16'h0);
      check("jmp5_instr", {16'h0, instrA}, 32'hABCD);

      // two-cycle stall with 16'h2222 in IF/ID
      mem[2] = 16'h3333;
      stepA("stl_rst", 1'b1, 1'b0, 1'b0, 16'h0);
      stepA("stl1", 1'b0, 1'b0, 1'b0, 16'h0);
      stepA("stl2", 1'b0, 1'b0, 1'b0, 16'h0);
      stepA("stl3", 1'b0, 1'b1, 1'b0, 16'h0);
      stepA("stl4", 1'b0, 1'b1, 1'b0, 16'h0);
      check("stl4_addr",  {16'h0, addrA},  32'h4);
      check("stl4_instr", {16'h0, instrA}, 32'h2222);
      check("stl4_fetch", {16'h0, fetchA}, 32'h2);
      stepA("stl5", 1'b0, 1'b0, 1'b0, 16'h0);
      check("stl5_instr", {16'h0, instrA}, 32'h3333);

      // branch together with stall and a jump in IF/ID
      mem[1] = 16'hE010; mem[128] = 16'h5555;
      stepA("brj_rst", 1'b1, 1'b0, 1'b0, 16'h0);
      stepA("brj1", 1'b0, 1'b0, 1'b0, 16'h0);
      stepA("brj2", 1'b0, 1'b0, 1'b0, 16'h0);
      stepA("brj3", 1'b0, 1'b1, 1'b1, 16'h0100);
      check("brj3_addr",  {16'h0, addrA},  32'h100);
      check("brj3_instr", {16'h0, instrA}, 32'h0);
      check("brj3_flush", {16'h0, flushA}, 32'h1);
      stepA("brj4", 1'b0, 1'b0, 1'b0, 16'h0);
      check("brj4_instr", {16'h0, instrA}, 32'h5555);

      // reset during a stall with a jump pending
      mem[0] = 16'hE010;
      stepA("rsj_rst", 1'b1, 1'b0, 1'b0, 16'h0);
      stepA("rsj1", 1'b0, 1'b0, 1'b0, 16'h0);
      stepA("rsj2", 1'b0, 1'b1, 1'b0, 16'h0);
      stepA("rsj3", 1'b1, 1'b1, 1'b0, 16'h0);
      check("rsj3_addr",  {16'h0, addrA},  32'h0);
      check("rsj3_fetch", {16'h0, fetchA}, 32'h0);
      check("rsj3_flush", {16'h0, flushA}, 32'h0);

      // PC wrap on the RESET_PC=16'hFFFC instance
      mem[16'h7FFE] = 16'h1111; mem[16'h7FFF] = 16'h2222; mem[0] = 16'h3333;
      resetB = 1'b1;
      stepA("wrp0", 1'b0, 1'b0, 1'b0, 16'h0);
      check("wrp0_addr",  {16'h0, addrB},  32'hFFFC);
      check("wrp0_valid", {31'h0, validB}, 32'h0);
      resetB = 1'b0;
      stepA("wrp1", 1'b0, 1'b0, 1'b0, 16'h0);
      check("wrp1_addr", {16'h0, addrB}, 32'hFFFE);
      check("wrp1_pc2",  {16'h0, pc2B},  32'hFFFE);
      stepA("wrp2", 1'b0, 1'b0, 1'b0, 16'h0);
      check("wrp2_addr", {16'h0, addrB}, 32'h0000);
      check("wrp2_pc2",  {16'h0, pc2B},  32'h0000);
      stepA("wrp3", 1'b0, 1'b0, 1'b0, 16'h0);
      check("wrp3_pc2",   {16'h0, pc2B},   32'h0002);
      check("wrp3_instr", {16'h0, instrB}, 32'h3333);

      // randomized traffic against the model
      stepA("rnd_rst", 1'b1, 1'b0, 1'b0, 16'h0);
      for (int n = 0; n < 400; n++) begin
         stepA("rnd", ($urandom_range(63) == 0), ($urandom_range(3) == 0),
               ($urandom_range(7) == 0), 16'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
